// File: rtl/icache_loader.sv
// Loads a byte stream into the instruction Sram as big-endian words, holding the GPP in reset until done.
// Optional readback verification is enabled by defining ICACHE_LOADER_VERIFY_EN.
module icache_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [ADDR_W:0]   Word_Count,
    input  logic [7:0]        In_Byte,
    input  logic              In_Valid,
    output logic              In_Ready,
    output logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] Di,
    input  logic [DATA_W-1:0] Data,
    output logic              RW,
    output logic              En,
    output logic              Cpu_Rst,
    output logic              Busy,
    output logic              Done,
    output logic              Error
);
    localparam int BYTES = DATA_W / 8;
    localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BI_W-1:0]   LAST_BYTE = BI_W'(BYTES - 1);
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] COLLECT = 3'd1;
    localparam logic [2:0] WRITE   = 3'd2;
    localparam logic [2:0] DONE    = 3'd3;
`ifdef ICACHE_LOADER_VERIFY_EN
    localparam logic [2:0] RD_REQ  = 3'd4;
    localparam logic [2:0] RD_CHK  = 3'd5;
`endif

    logic [2:0]        state_reg;
    logic [ADDR_W:0]   n_reg;
    logic [ADDR_W:0]   idx_reg;
    logic [BI_W-1:0]   byte_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] di_reg;
    logic [DATA_W-1:0] csum_reg;

    logic              start_ok;
    logic              take;
    logic [ADDR_W:0]   n_clamp;
    logic [ADDR_W:0]   idx_inc;
    logic [DATA_W-1:0] word_next;

    assign start_ok  = Start && (state_reg == IDLE || state_reg == DONE);
    assign take      = In_Valid && In_Ready;
    assign n_clamp   = (Word_Count > DEPTH_C) ? DEPTH_C : Word_Count;
    assign idx_inc   = idx_reg + 1'b1;
    // First byte of a word ends up in the most significant lane after all shifts.
    assign word_next = (shift_reg << 8) | DATA_W'(In_Byte);

`ifdef ICACHE_LOADER_VERIFY_EN
    logic [DATA_W-1:0] rd_csum_reg;
    logic              error_reg;
    assign Error = error_reg;
    assign En    = (state_reg == WRITE) || (state_reg == RD_REQ);
`else
    logic unused_data;
    assign unused_data = ^Data;
    assign Error = 1'b0;
    assign En    = (state_reg == WRITE);
`endif

    assign In_Ready = (state_reg == COLLECT);
    assign RW       = (state_reg == WRITE);
    assign Addr     = addr_reg;
    assign Di       = di_reg;
    assign Done     = (state_reg == DONE);
    assign Cpu_Rst  = (state_reg != DONE);
    assign Busy     = (state_reg != IDLE) && (state_reg != DONE);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_reg   <= IDLE;
            n_reg       <= '0;
            idx_reg     <= '0;
            byte_reg    <= '0;
            shift_reg   <= '0;
            addr_reg    <= '0;
            di_reg      <= '0;
            csum_reg    <= '0;
`ifdef ICACHE_LOADER_VERIFY_EN
            rd_csum_reg <= '0;
            error_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start_ok) begin
                        n_reg     <= n_clamp;
                        idx_reg   <= '0;
                        byte_reg  <= '0;
                        shift_reg <= '0;
                        csum_reg  <= '0;
`ifdef ICACHE_LOADER_VERIFY_EN
                        error_reg <= 1'b0;
`endif
                        state_reg <= (n_clamp == '0) ? DONE : COLLECT;
                    end
                end
                COLLECT: begin
                    if (take) begin
                        shift_reg <= word_next;
                        if (byte_reg == LAST_BYTE) begin
                            byte_reg  <= '0;
                            addr_reg  <= idx_reg[ADDR_W-1:0];
                            di_reg    <= word_next;
                            state_reg <= WRITE;
                        end else begin
                            byte_reg <= byte_reg + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    csum_reg <= csum_reg ^ di_reg;
                    idx_reg  <= idx_inc;
                    if (idx_inc == n_reg) begin
`ifdef ICACHE_LOADER_VERIFY_EN
                        idx_reg     <= '0;
                        addr_reg    <= '0;
                        rd_csum_reg <= '0;
                        state_reg   <= RD_REQ;
`else
                        state_reg   <= DONE;
`endif
                    end else begin
                        state_reg <= COLLECT;
                    end
                end
`ifdef ICACHE_LOADER_VERIFY_EN
                RD_REQ: state_reg <= RD_CHK;
                RD_CHK: begin
                    // Data reflects the read issued in the preceding RD_REQ cycle.
                    rd_csum_reg <= rd_csum_reg ^ Data;
                    idx_reg     <= idx_inc;
                    if (idx_inc == n_reg) begin
                        error_reg <= ((rd_csum_reg ^ Data) != csum_reg);
                        state_reg <= DONE;
                    end else begin
                        addr_reg  <= idx_inc[ADDR_W-1:0];
                        state_reg <= RD_REQ;
                    end
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
